// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the byte-enabled data memory.
// Size codes, lane masks and alignment masks used by data_mem_be.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Byte lanes touched by an access of this size at this lane offset.
  function automatic logic [7:0] lane_mask(
    input logic [1:0] size,
    input logic [2:0] lo
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      size == SZ_BYTE:  m = 8'h01;
      size == SZ_HALF:  m = 8'h03;
      size == SZ_WORD:  m = 8'h0f;
      size == SZ_DWORD: m = 8'hff;
    endcase
    return m << lo;
  endfunction

  function automatic logic [2:0] off_mask(
    input logic [1:0] size
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (1'b1)
      size == SZ_BYTE:  m = 3'b000;
      size == SZ_HALF:  m = 3'b001;
      size == SZ_WORD:  m = 3'b011;
      size == SZ_DWORD: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Load-path alignment: shift selected lanes to bit 0,
// then zero- or sign-extend to the full word.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        lo,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] sh;
  logic [6:0]        nbits;
  logic              top;
  logic              fill;

  always_comb begin
    sh    = word >> {lo, 3'b000};
    nbits = 7'd8 << size;
    top   = sh[DATA_W-1];
    unique case (1'b1)
      size == SZ_BYTE:  top = sh[7];
      size == SZ_HALF:  top = sh[15];
      size == SZ_WORD:  top = sh[31];
      size == SZ_DWORD: top = sh[DATA_W-1];
    endcase
    // Full-width loads never extend, whatever sext says.
    fill = sext && (int'(nbits) < DATA_W) && top;
    for (int i = 0; i < DATA_W; i++) begin
      rdata[i] = (i < int'(nbits)) ? sh[i] : fill;
    end
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-enabled data memory with one-deep response register.
// Optional per-byte even parity under DATA_MEM_PARITY_EN.
module data_mem_be
  import data_mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int NB     = DATA_W / 8,
  localparam int ADDR_W = $clog2(DEPTH) + $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam bit HAS_DW = (DATA_W == 64);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        lo;
  logic [7:0]        mask8;
  logic [NB-1:0]     be;
  logic              bad;
  logic              wr_ok;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data;

  // rst_n gates ready so nothing is taken while in reset.
  assign req_ready = rst_n && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign idx     = req_addr[ADDR_W-1:OFF_W];
  assign lo      = 3'(req_addr[OFF_W-1:0]);
  assign mask8   = lane_mask(req_size, lo);
  assign be      = mask8[NB-1:0];
  assign bad     = (!HAS_DW && req_size == SZ_DWORD)
                || (|(lo & off_mask(req_size)))
                || (|(mask8 >> NB));
  assign wr_ok   = accept && req_write && !bad;
  assign wsh     = req_wdata << {lo, 3'b000};
  assign rd_word = mem[idx];

  data_mem_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .word  (rd_word),
    .lo    (lo),
    .size  (req_size),
    .sext  (req_signed),
    .rdata (ld_data)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par;
  logic          perr_d;

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      wr_par[b] = ^wsh[8*b +: 8];
      rd_par[b] = ^rd_word[8*b +: 8];
    end
    perr_d = |(be & (rd_par ^ par[idx]));
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) par[idx][b] <= wr_par[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_perr <= 1'b0;
    end else if (accept) begin
      rsp_perr <= !bad && !req_write && perr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (bad || req_write) ? '0 : ld_data;
      rsp_err   <= bad;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Scoreboard bench for data_mem_be: byte-level memory model,
// directed stimulus, checks sampled on the falling edge.
module tb_data_mem_be;

  localparam int DW = 32;
  localparam int DP = 256;
  localparam int AW = 10;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
`ifdef DATA_MEM_PARITY_EN
  logic          rsp_perr;
`endif

  exp_t       q[$];
  logic [7:0] mref [1 << AW];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_be #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
`ifdef DATA_MEM_PARITY_EN
    ,
    .rsp_perr   (rsp_perr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Little-endian byte model; updates mref on stores.
  function automatic exp_t model(input logic w, input logic [1:0] sz,
                                 input logic sg, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd);
    exp_t          e;
    int            n;
    logic [DW-1:0] v;
    e = '0;
    n = 1 << sz;
    if (sz == 2'd3 || (int'(a) % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (w) begin
      for (int k = 0; k < n; k++) mref[int'(a) + k] = wd[8*k +: 8];
      return e;
    end
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mref[int'(a) + k];
    if (sg && n < 4 && v[8*n-1]) begin
      for (int i = 8 * n; i < DW; i++) v[i] = 1'b1;
    end
    e.rdata = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_valid", rsp_valid, q.size() != 0);
      if (rsp_valid && q.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, q[0].rdata);
        chk("rsp_err", rsp_err, q[0].err);
        if (rsp_ready) void'(q.pop_front());
      end
      if (req_valid && req_ready) begin
        q.push_back(model(req_write, req_size, req_signed,
                          req_addr, req_wdata));
      end
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic wait_acc(input string tag);
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    n_vec++;
    if (t == 50) begin
      n_bad++;
      $display("FAIL %s: accept timeout, observed no ready, expected ready", tag);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic w, input logic [1:0] sz,
                      input logic sg, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    drive(w, sz, sg, a, wd);
    wait_acc("send");
  endtask

  task automatic direct(input string tag, input logic [DW-1:0] exp);
    @(negedge clk);
    chk(tag, rsp_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    req_valid = 1'b1;
    #12;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(1, 2'd2, 0, 'h10, 32'h89ABCDEF);
    send(0, 2'd0, 1, 'h13, 0);
    direct("ld_b_sx", 32'hFFFFFF89);
    send(0, 2'd0, 0, 'h13, 0);
    send(0, 2'd1, 1, 'h12, 0);
    send(0, 2'd2, 1, 'h10, 0);

    send(1, 2'd2, 0, 'h20, 32'h55667788);
    send(1, 2'd1, 0, 'h22, 32'hFFFF1234);
    send(0, 2'd2, 0, 'h20, 0);
    direct("half_merge", 32'h12347788);

    send(1, 2'd2, 0, 'h04, 32'hCAFEF00D);
    send(1, 2'd2, 0, 'h06, 32'h11111111);
    send(1, 2'd1, 0, 'h05, 32'h2222);
    send(0, 2'd2, 0, 'h06, 0);
    send(0, 2'd3, 0, 'h08, 0);
    send(0, 2'd2, 0, 'h04, 0);
    direct("misalign_nochg", 32'hCAFEF00D);

    send(0, 2'd2, 0, 'h10, 0);
    rsp_ready = 1'b0;
    drive(0, 2'd0, 0, 'h21, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", req_ready, 0);
      chk("stall_hold", rsp_rdata, 32'h89ABCDEF);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_acc("stall");
    c0 = cyc;
    send(0, 2'd1, 0, 'h20, 0);
    send(0, 2'd0, 1, 'h23, 0);
    send(1, 2'd0, 0, 'h11, 32'h7F);
    send(0, 2'd2, 0, 'h10, 0);
    chk("throughput", 64'(cyc - c0), 4);

    send(1, 2'd2, 0, 'h30, 32'hDEADBEEF);
    send(0, 2'd2, 0, 'h30, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_rdata", rsp_rdata, 0);
    chk("arst_err", rsp_err, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 2'd2, 0, 'h30, 0);
    direct("keep_30", 32'hDEADBEEF);
    send(0, 2'd2, 0, 'h04, 0);
    direct("keep_04", 32'hCAFEF00D);

`ifdef DATA_MEM_PARITY_EN
    send(1, 2'd2, 0, 'h40, 32'h01020304);
    dut.par[16][1] = ~dut.par[16][1];
    send(0, 2'd0, 0, 'h41, 0);
    @(negedge clk);
    chk("perr_bad", rsp_perr, 1);
    @(posedge clk);
    #1;
    send(0, 2'd0, 0, 'h40, 0);
    @(negedge clk);
    chk("perr_ok", rsp_perr, 0);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; power of two, at least 4.
REQ-003 SHALL derive NB = DATA_W/8 and ADDR_W = $clog2(DEPTH) + $clog2(NB) as localparams; they are not overridable.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2, access size: 0 byte, 1 half, 2 word32, 3 dword (legal only when DATA_W = 64).
REQ-010 SHALL have port req_signed, input, 1, sign-extend load data when 1.
REQ-011 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-012 SHALL have port req_wdata, input, DATA_W, store data, right-aligned in bits [8*2^size-1:0].
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, load data, aligned and extended; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1, misaligned or illegal-size access.

Function
REQ-017 Requests SHALL pass through a single response register; req_ready = !rsp_valid || rsp_ready, with no combinational path from req_valid to req_ready.
REQ-018 An accepted request SHALL produce exactly one response, with rsp_valid high on the cycle after acceptance.
REQ-019 Responses SHALL be returned in acceptance order; rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-020 A request is misaligned when req_addr mod 2^req_size != 0; a misaligned or illegal-size request SHALL leave memory unchanged and respond rsp_err=1, rsp_rdata=0.
REQ-021 A store SHALL write only the byte lanes selected by size and by the low address bits, on the acceptance edge.
REQ-022 A load accepted on the cycle after a store to the same word SHALL return the newly stored data, with no stall.
REQ-023 A load SHALL shift the selected lanes to bit 0, then zero-extend, or sign-extend from the top selected bit when req_signed=1; req_signed SHALL be ignored for full-width loads.
REQ-024 Back-to-back accepted requests with rsp_ready held high SHALL sustain one request per cycle.

Reset
REQ-025 On assertion of rst_n low, rsp_valid, rsp_rdata and rsp_err SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-026 The memory array SHALL NOT be reset; a response in flight when reset asserts SHALL be discarded.
REQ-027 A store accepted on the same edge that reset deasserts SHALL NOT occur, because req_ready is 0 while rst_n is low.

Configuration
REQ-028 With macro DATA_MEM_PARITY_EN defined, one even-parity bit per byte SHALL be stored on every write.
REQ-029 With DATA_MEM_PARITY_EN defined, the parity of the accessed lanes SHALL be checked on every load, and output port rsp_perr (1 bit, reset 0, timed and held like rsp_err) SHALL report any mismatch; load data SHALL still be returned.
REQ-030 Without DATA_MEM_PARITY_EN, neither the parity storage nor the rsp_perr port SHALL exist.

Structure
REQ-031 Package data_mem_pkg SHALL hold the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and a lane-mask function taking size and low address bits.
REQ-032 Load alignment and extension SHALL live in sub-module data_mem_align, which is combinational; the parent owns the memory array, the handshake and the response register.

Verification
REQ-033 Store word 0x89ABCDEF at address 0x10, then load byte at 0x13 with signed=1 -> rsp_rdata=0xFFFFFF89, rsp_err=0, one cycle after acceptance.
REQ-034 Store half 0x1234 at 0x22, then load word at 0x20 -> upper half reads 0x1234 and the lower half is unchanged from its prior value.
REQ-035 Load word at 0x06 -> rsp_err=1 and rsp_rdata=0; then load word at 0x04 -> prior contents returned, proving the misaligned access changed nothing.
REQ-036 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and the response holds stable; release -> one response per cycle and no request is lost.
REQ-037 Assert rst_n low mid-stream -> rsp_valid falls within the same cycle; after release, memory contents are preserved.
REQ-038 With DATA_MEM_PARITY_EN defined, flip one stored bit by backdoor, then load that byte -> rsp_perr=1; load a different byte of the same word -> rsp_perr=0.
